// File: rtl/trade_pkg.sv
// Shared types and constants for the order transmit path.
// Defining ORDER_CHECKSUM_EN selects a 5-byte frame with a trailing XOR checksum byte.
package trade_pkg;

  typedef enum logic [1:0] {
    SIDE_NONE = 2'b00,
    SIDE_BUY  = 2'b01,
    SIDE_SELL = 2'b10
  } side_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_COOL
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

`ifdef ORDER_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  localparam int IDX_W = $clog2(FRAME_LEN);

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

endpackage

// File: rtl/order_frame_ser.sv
// Latches one order frame and streams it byte-serially; tx_data holds while stalled.
// Checksum byte is appended when ORDER_CHECKSUM_EN is defined.
module order_frame_ser
  import trade_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEFAULT,
  parameter logic [7:0] QTY  = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  side_t      side_i,
  input  logic [5:0] seq_i,
  input  logic [7:0] price_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  frame_t           frame_q, frame_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [7:0]       b1;

  assign b1 = {side_i, seq_i};

  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    if (load_i) begin
      frame_d[0] = SYNC;
      frame_d[1] = b1;
      frame_d[2] = price_i;
      frame_d[3] = QTY;
`ifdef ORDER_CHECKSUM_EN
      frame_d[4] = b1 ^ price_i ^ QTY;
`endif
      idx_d = '0;
      vld_d = 1'b1;
    end else if (vld_q && tx_ready_i) begin
      // Index only moves on a handshake, so the output byte is stable under backpressure.
      if (idx_q == LAST_IDX) begin
        vld_d = 1'b0;
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign tx_data_o  = frame_q[idx_q];
  assign tx_valid_o = vld_q;
  assign done_o     = vld_q & tx_ready_i & (idx_q == LAST_IDX);

endmodule

// File: rtl/order_tx.sv
// Turns buy/sell edges into order frames with a net-position limit and post-frame cooldown.
// Frame length follows ORDER_CHECKSUM_EN (5 bytes when defined, otherwise 4).
module order_tx
  import trade_pkg::*;
#(
  parameter logic [7:0] QTY      = 8'd1,
  parameter logic [7:0] MAX_POS  = 8'd16,
  parameter logic [7:0] COOLDOWN = 8'd4,
  parameter logic [7:0] SYNC     = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buy_signal,
  input  logic              sell_signal,
  input  logic [7:0]        price,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic signed [8:0] position,
  output logic [7:0]        drop_cnt
);

  localparam logic signed [9:0] QTY_S = $signed({2'b00, QTY});
  localparam logic signed [9:0] MAX_S = $signed({2'b00, MAX_POS});
  localparam logic signed [8:0] QTY9  = $signed({1'b0, QTY});

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic signed [8:0] pos_q, pos_d;
  logic [5:0]        seq_q, seq_d;
  logic [7:0]        drop_q, drop_d;
  logic              buy_q, sell_q;
  logic              evt_buy, evt_sell, drop_inc, load, ser_done, buy_ok, sell_ok;
  logic signed [9:0] pos_ext;
  side_t             side;

  assign evt_buy  = buy_signal & ~buy_q;
  assign evt_sell = sell_signal & ~sell_q;
  assign pos_ext  = {pos_q[8], pos_q};
  assign buy_ok   = (pos_ext + QTY_S) <= MAX_S;
  assign sell_ok  = (pos_ext - QTY_S) >= -MAX_S;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    seq_d    = seq_q;
    drop_inc = 1'b0;
    load     = 1'b0;
    side     = SIDE_NONE;
    case (state_q)
      ST_IDLE: begin
        if (evt_buy && evt_sell) begin
          drop_inc = 1'b1;
        end else if (evt_buy) begin
          if (buy_ok) begin
            load    = 1'b1;
            side    = SIDE_BUY;
            pos_d   = pos_q + QTY9;
            seq_d   = seq_q + 6'd1;
            state_d = ST_SEND;
          end else begin
            drop_inc = 1'b1;
          end
        end else if (evt_sell) begin
          if (sell_ok) begin
            load    = 1'b1;
            side    = SIDE_SELL;
            pos_d   = pos_q - QTY9;
            seq_d   = seq_q + 6'd1;
            state_d = ST_SEND;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_SEND: begin
        drop_inc = evt_buy | evt_sell;
        if (ser_done) begin
          cnt_d   = COOLDOWN;
          state_d = ST_COOL;
        end
      end
      ST_COOL: begin
        drop_inc = evt_buy | evt_sell;
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      buy_q   <= 1'b0;
      sell_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      buy_q   <= buy_signal;
      sell_q  <= sell_signal;
    end
  end

  order_frame_ser #(.SYNC(SYNC), .QTY(QTY)) u_ser (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (load),
    .side_i    (side),
    .seq_i     (seq_q),
    .price_i   (price),
    .tx_ready_i(tx_ready),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .done_o    (ser_done)
  );

  assign busy     = (state_q != ST_IDLE);
  assign position = pos_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_order_tx.sv
// Directed bench for order_tx (MAX_POS overridden to 2 so the limit is reachable).
module tb_order_tx;

`ifdef ORDER_CHECKSUM_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              buy_signal;
  logic              sell_signal;
  logic [7:0]        price;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic signed [8:0] position;
  logic [7:0]        drop_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          frames   = 0;
  logic        vld_prev = 1'b0;
  logic [7:0]  exp_b [5];

  always #5 clk = ~clk;

  order_tx #(.QTY(8'd1), .MAX_POS(8'd2), .COOLDOWN(8'd4), .SYNC(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .buy_signal (buy_signal),
    .sell_signal(sell_signal),
    .price      (price),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .position   (position),
    .drop_cnt   (drop_cnt)
  );

  // Frame counter: rising edges of tx_valid, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (tx_valid && !vld_prev) frames++;
    vld_prev = tx_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; buy_signal = 1'b0; sell_signal = 1'b0; price = 8'h00; tx_ready = 1'b1;
    step(2);
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (position !== 9'sd0) begin n_fail++; $display("FAIL reset_position got %0d want 0", position); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_buy_frame;
    exp_b = '{8'hA5, 8'h40, 8'h40, 8'h01, 8'h01};
    tx_ready = 1'b1; price = 8'h40; buy_signal = 1'b1;
    for (int i = 0; i < FL; i++) begin
      step(1);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        n_fail++; $display("FAIL buy_byte%0d got vld=%b data=%h want vld=1 data=%h", i, tx_valid, tx_data, exp_b[i]);
      end
      if (i == 0) begin
        n_checks++; if (position !== 9'sd1) begin n_fail++; $display("FAIL buy_position got %0d want 1", position); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL buy_busy got %b want 1", busy); end
      end
    end
    step(1);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL buy_end_valid got %b want 0", tx_valid); end
    buy_signal = 1'b0; price = 8'h00;
    step(12);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL buy_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_sell_stall;
    int idx;
    exp_b = '{8'hA5, 8'h81, 8'h33, 8'h01, 8'hB3};
    idx = 0;
    tx_ready = 1'b0; price = 8'h33; sell_signal = 1'b1;
    for (int cyc = 0; cyc < 40 && idx < FL; cyc++) begin
      step(1);
      if (tx_valid) begin
        n_checks++;
        if (tx_data !== exp_b[idx]) begin
          n_fail++; $display("FAIL sell_byte%0d cyc%0d got %h want %h", idx, cyc, tx_data, exp_b[idx]);
        end
        tx_ready = cyc[0];
        if (tx_ready) idx++;
      end
    end
    n_checks++; if (idx != FL) begin n_fail++; $display("FAIL sell_bytes_seen got %0d want %0d", idx, FL); end
    tx_ready = 1'b1; sell_signal = 1'b0;
    step(1);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL sell_end_valid got %b want 0", tx_valid); end
    n_checks++; if (position !== 9'sd0) begin n_fail++; $display("FAIL sell_position got %0d want 0", position); end
    step(12);
  endtask

  task automatic test_held_buy;
    int f0;
    f0 = frames;
    buy_signal = 1'b1; price = 8'h55;
    step(10);
    buy_signal = 1'b0;
    step(12);
    n_checks++; if (frames - f0 != 1) begin n_fail++; $display("FAIL held_frames got %0d want 1", frames - f0); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL held_drop_cnt got %0d want 0", drop_cnt); end
    n_checks++; if (position !== 9'sd1) begin n_fail++; $display("FAIL held_position got %0d want 1", position); end
  endtask

  task automatic test_conflict;
    buy_signal = 1'b1; sell_signal = 1'b1;
    step(1);
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL conflict_drop_cnt got %0d want 1", drop_cnt); end
    n_checks++; if (position !== 9'sd1) begin n_fail++; $display("FAIL conflict_position got %0d want 1", position); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL conflict_busy got %b want 0", busy); end
    buy_signal = 1'b0; sell_signal = 1'b0;
    step(3);
    n_checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL conflict_no_frame got busy=%b vld=%b want 0/0", busy, tx_valid);
    end
  endtask

  task automatic test_limit;
    int f0;
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    f0 = frames;
    repeat (3) begin
      buy_signal = 1'b1;
      step(1);
      buy_signal = 1'b0;
      step(15);
    end
    n_checks++; if (frames - f0 != 2) begin n_fail++; $display("FAIL limit_frames got %0d want 2", frames - f0); end
    n_checks++; if (position !== 9'sd2) begin n_fail++; $display("FAIL limit_position got %0d want 2", position); end
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL limit_drop_cnt got %0d want 1", drop_cnt); end
  endtask

  task automatic test_reset_mid_send;
    tx_ready = 1'b0; price = 8'h77; sell_signal = 1'b1;
    step(3);
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL midsend_valid got %b want 1", tx_valid); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", tx_valid); end
    n_checks++; if (position !== 9'sd0) begin n_fail++; $display("FAIL midrst_position got %0d want 0", position); end
    n_checks++; if (busy !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL midrst_state got busy=%b drop=%0d want 0/0", busy, drop_cnt);
    end
    sell_signal = 1'b0; tx_ready = 1'b1;
    step(1);
    rst = 1'b1;
    step(1);
    exp_b = '{8'hA5, 8'h40, 8'h40, 8'h01, 8'h01};
    price = 8'h40; buy_signal = 1'b1;
    for (int i = 0; i < FL; i++) begin
      step(1);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        n_fail++; $display("FAIL postrst_byte%0d got vld=%b data=%h want vld=1 data=%h", i, tx_valid, tx_data, exp_b[i]);
      end
    end
    step(1);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_end_valid got %b want 0", tx_valid); end
    buy_signal = 1'b0;
    step(12);
  endtask

  initial begin
    test_reset;
    test_buy_frame;
    test_sell_stall;
    test_held_buy;
    test_conflict;
    test_limit;
    test_reset_mid_send;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
